// File: rtl/gpu_mem_port_arbiter.sv
// Round-robin arbiter that funnels NUM_PORTS queued requesters onto a single
// memory port carrying one outstanding transaction at a time.

module gpu_mem_port_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] store;
    logic [AW-1:0]           wr_ptr, rd_ptr;

    // Power-of-two depth lets the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= din;
    end

    assign dout = store[rd_ptr];
endmodule

module gpu_mem_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 40,
    parameter int QDEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]          rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ack,
    output logic [31:0]                   read_count,
    output logic [31:0]                   write_count,
    output logic [31:0]                   stall_cycles
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                          state;
    entry_t [NUM_PORTS-1:0]          push_ent, head;
    logic   [NUM_PORTS-1:0][CW-1:0]  occ;
    logic   [NUM_PORTS-1:0]          push, pop, nonempty;
    logic   [PW-1:0]                 last_grant, sel, cand;
    logic                            found, grant_now;
    int                              idx;

    assign grant_now = (state == IDLE) && found;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign push_ent[p] = '{we:    req_we[p],
                               addr:  req_addr[p*ADDR_W +: ADDR_W],
                               wdata: req_wdata[p*DATA_W +: DATA_W]};
        assign req_ready[p] = occ[p] < CW'(QDEPTH);
        assign nonempty[p]  = occ[p] != '0;
        assign push[p]      = req_valid[p] & req_ready[p];
        assign pop[p]       = grant_now && (sel == PW'(p));

        gpu_mem_port_fifo #(.W($bits(entry_t)), .DEPTH(QDEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[p]),
            .pop   (pop[p]),
            .din   (push_ent[p]),
            .dout  (head[p]),
            .count (occ[p])
        );
    end

    // Search upward from the port after the last winner, wrapping once.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        idx   = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            cand = PW'(idx);
            if (!found && nonempty[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            read_count   <= '0;
            write_count  <= '0;
            stall_cycles <= '0;
            last_grant   <= PW'(NUM_PORTS - 1);
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        mem_req    <= 1'b1;
                        mem_we     <= head[sel].we;
                        mem_addr   <= head[sel].addr;
                        mem_wdata  <= head[sel].wdata;
                        last_grant <= sel;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        rsp_valid <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << last_grant;
                        rsp_data  <= mem_we ? '0 : mem_rdata;
                        if (mem_we) write_count <= write_count + 32'd1;
                        else        read_count  <= read_count + 32'd1;
                        state     <= IDLE;
                    end else begin
                        stall_cycles <= stall_cycles + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
